ctrl_seq: RTL and testbench

- Multi-cycle control sequencer; next generation of the combinational control decoder.
- Decodes the 9-bit ISA opcode field and drives fetch unit, register file and data memory.
- Adds a run/halt state machine, parametrised memory wait states, in-block branch resolution against the ALU flag, and a saturating retired-instruction counter.
- Sits between instruction ROM / ALU flag and program_counter, register file and data memory.

---
 rtl/ctrl_seq.sv | 147 ++++++++++++++
 tb/tb_ctrl_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - multi-cycle control sequencer with run/halt FSM, memory wait states and retired count
module ctrl_seq #(
  parameter int INSTR_W = 9,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               Flag,
  output logic               PcEn,
  output logic               BranchEn,
  output logic               BranchOnFlag,
  output logic               BranchTaken,
  output logic               WriteEn,
  output logic               RegEn,
  output logic               RegWriteBack,
  output logic               Done,
  output logic [CNT_W-1:0]   InstrCnt
);

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, HALTED} state_t;

  localparam logic [3:0] OP_LOAD    = 4'b0000;
  localparam logic [3:0] OP_STORE   = 4'b0001;
  localparam logic [3:0] OP_SHIFTL  = 4'b0010;
  localparam logic [3:0] OP_SHIFTR  = 4'b0011;
  localparam logic [3:0] OP_ARITH   = 4'b0100;
  localparam logic [3:0] OP_LOGICAL = 4'b0101;
  localparam logic [3:0] OP_COMPARE = 4'b0110;
  localparam logic [3:0] OP_BNE     = 4'b0111;
  localparam logic [3:0] OP_BEQ     = 4'b1000;
  localparam logic [3:0] OP_JUMP    = 4'b1001;
  localparam logic [3:0] OP_LOADI   = 4'b1010;
  localparam logic [3:0] OP_MOVE    = 4'b1011;
  localparam logic [3:0] OP_SHIFTC  = 4'b1100;
  localparam logic [3:0] OP_ADDI    = 4'b1101;
  localparam logic [3:0] OP_SUBI    = 4'b1110;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  localparam int LAT_M1 = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic [3:0] opcode;
  logic [1:0] funct;
  logic       mem_last;
  logic       unused_bits;

  assign opcode      = Instruction[INSTR_W-1 -: 4];
  assign funct       = Instruction[1:0];
  assign unused_bits = ^Instruction[INSTR_W-5:2];

  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    mem_last     = 1'b0;
    PcEn         = 1'b0;
    BranchEn     = 1'b0;
    BranchOnFlag = 1'b0;
    WriteEn      = 1'b0;
    RegEn        = 1'b0;
    RegWriteBack = 1'b0;
    unique case (state)
      IDLE, HALTED: begin
        if (Start) state_nxt = RUN;
      end
      RUN, MEM_WAIT: begin
        state_nxt = RUN;
        unique case (opcode)
          OP_LOAD, OP_STORE: begin
            // Op occupies MEM_LAT+1 cycles; retirement happens only on the last one.
            if (MEM_LAT == 0) begin
              mem_last = 1'b1;
            end else if (state == RUN) begin
              wait_nxt  = 4'(LAT_M1);
              state_nxt = MEM_WAIT;
            end else if (wait_cnt == 4'd0) begin
              mem_last = 1'b1;
            end else begin
              wait_nxt  = wait_cnt - 4'd1;
              state_nxt = MEM_WAIT;
            end
            PcEn    = mem_last;
            WriteEn = (opcode == OP_STORE);
            RegEn   = (opcode == OP_LOAD) && mem_last;
          end
          OP_SHIFTL, OP_SHIFTR, OP_SHIFTC, OP_ADDI, OP_SUBI: begin
            PcEn         = 1'b1;
            RegEn        = 1'b1;
            RegWriteBack = 1'b1;
          end
          OP_ARITH, OP_LOGICAL, OP_LOADI: begin
            PcEn  = 1'b1;
            RegEn = 1'b1;
          end
          OP_COMPARE, OP_JUMP: begin
            PcEn = 1'b1;
          end
          OP_BNE: begin
            PcEn     = 1'b1;
            BranchEn = 1'b1;
          end
          OP_BEQ: begin
            PcEn         = 1'b1;
            BranchEn     = 1'b1;
            BranchOnFlag = 1'b1;
          end
          OP_MOVE: begin
            PcEn         = 1'b1;
            RegEn        = 1'b1;
            RegWriteBack = (funct == 2'b00);
          end
          OP_HALT: begin
            state_nxt = HALTED;
          end
          default: begin
            PcEn = 1'b1;
          end
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign BranchTaken = BranchEn & (Flag == BranchOnFlag);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      InstrCnt <= '0;
      Done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      Done     <= (state_nxt == HALTED);
      if ((state == IDLE || state == HALTED) && Start) begin
        InstrCnt <= '0;
      end else if (PcEn && (InstrCnt != {CNT_W{1'b1}})) begin
        InstrCnt <= InstrCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - directed self-checking bench for ctrl_seq
module tb_ctrl_seq;

  localparam logic [3:0] OP_LOAD    = 4'b0000;
  localparam logic [3:0] OP_STORE   = 4'b0001;
  localparam logic [3:0] OP_SHIFTL  = 4'b0010;
  localparam logic [3:0] OP_COMPARE = 4'b0110;
  localparam logic [3:0] OP_BNE     = 4'b0111;
  localparam logic [3:0] OP_BEQ     = 4'b1000;
  localparam logic [3:0] OP_MOVE    = 4'b1011;
  localparam logic [3:0] OP_ADDI    = 4'b1101;
  localparam logic [3:0] OP_SUBI    = 4'b1110;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  logic       clk = 1'b0;
  logic       reset, start, flag;
  logic [8:0] instr;
  logic       pc_en, br_en, br_on, br_taken, wr_en, reg_en, reg_wb, done;
  logic [15:0] cnt;

  logic       reset0, start0, flag0;
  logic [8:0] instr0;
  logic       pc_en0, br_en0, br_on0, br_taken0, wr_en0, reg_en0, reg_wb0, done0;
  logic [1:0] cnt0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_seq #(.INSTR_W(9), .MEM_LAT(2), .CNT_W(16)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .Instruction(instr), .Flag(flag),
    .PcEn(pc_en), .BranchEn(br_en), .BranchOnFlag(br_on), .BranchTaken(br_taken),
    .WriteEn(wr_en), .RegEn(reg_en), .RegWriteBack(reg_wb), .Done(done), .InstrCnt(cnt)
  );

  ctrl_seq #(.INSTR_W(9), .MEM_LAT(0), .CNT_W(2)) dut0 (
    .Clk(clk), .Reset(reset0), .Start(start0), .Instruction(instr0), .Flag(flag0),
    .PcEn(pc_en0), .BranchEn(br_en0), .BranchOnFlag(br_on0), .BranchTaken(br_taken0),
    .WriteEn(wr_en0), .RegEn(reg_en0), .RegWriteBack(reg_wb0), .Done(done0), .InstrCnt(cnt0)
  );

  function automatic logic [8:0] mk(input logic [3:0] op, input logic [1:0] fn);
    return {op, 3'b000, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flag = 1'b0; instr = mk(OP_ADDI, 2'b00);
    reset0 = 1'b1; start0 = 1'b0; flag0 = 1'b0; instr0 = mk(OP_COMPARE, 2'b00);
    tick(); tick();
    check("rst_pcen", pc_en, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cnt, 0);
    check("rst_regen", reg_en, 0);
    reset = 1'b0;
    #1 check("idle_pcen", pc_en, 0);
    check("idle_regen", reg_en, 0);
    start = 1'b1;
    tick();
    start = 1'b0;

    instr = mk(OP_ADDI, 2'b00);
    #1 check("addi_pcen", pc_en, 1); check("addi_regen", reg_en, 1); check("addi_wb", reg_wb, 1);
    tick(); instr = mk(OP_SHIFTL, 2'b00);
    #1 check("shl_pcen", pc_en, 1); check("shl_regen", reg_en, 1); check("shl_wb", reg_wb, 1);
    tick(); instr = mk(OP_SUBI, 2'b00);
    #1 check("subi_pcen", pc_en, 1); check("subi_regen", reg_en, 1); check("subi_wb", reg_wb, 1);
    tick();
    check("cnt_after3", cnt, 3);

    instr = mk(OP_STORE, 2'b00);
    for (int i = 0; i < 3; i++) begin
      #1 check("st_we", wr_en, 1);
      check("st_pcen", pc_en, (i == 2) ? 1 : 0);
      check("st_regen", reg_en, 0);
      tick();
    end
    check("cnt_after_st", cnt, 4);

    instr = mk(OP_LOAD, 2'b00);
    for (int i = 0; i < 3; i++) begin
      #1 check("ld_regen", reg_en, (i == 2) ? 1 : 0);
      check("ld_pcen", pc_en, (i == 2) ? 1 : 0);
      check("ld_we", wr_en, 0);
      check("ld_wb", reg_wb, 0);
      tick();
    end
    check("cnt_after_ld", cnt, 5);

    instr = mk(OP_BEQ, 2'b00); flag = 1'b1;
    #1 check("beq1_taken", br_taken, 1); check("beq1_pcen", pc_en, 1); check("beq1_bren", br_en, 1);
    tick(); flag = 1'b0;
    #1 check("beq0_taken", br_taken, 0); check("beq0_pcen", pc_en, 1);
    tick(); instr = mk(OP_BNE, 2'b00);
    #1 check("bne0_taken", br_taken, 1); check("bne0_pcen", pc_en, 1); check("bne_on", br_on, 0);
    tick();

    instr = mk(OP_MOVE, 2'b00);
    #1 check("mov00_wb", reg_wb, 1); check("mov00_regen", reg_en, 1);
    tick(); instr = mk(OP_MOVE, 2'b01);
    #1 check("mov01_wb", reg_wb, 0); check("mov01_regen", reg_en, 1);
    tick();
    check("cnt_after_mov", cnt, 10);

    instr = mk(OP_HALT, 2'b00);
    #1 check("halt_pcen", pc_en, 0); check("halt_regen", reg_en, 0); check("halt_done", done, 0);
    tick();
    check("halted_done", done, 1); check("halted_cnt", cnt, 10); check("halted_pcen", pc_en, 0);
    tick();
    check("halted_done2", done, 1); check("halted_cnt2", cnt, 10);
    start = 1'b1;
    tick();
    start = 1'b0; instr = mk(OP_COMPARE, 2'b00);
    #1 check("restart_done", done, 0); check("restart_cnt", cnt, 0);
    check("restart_pcen", pc_en, 1); check("cmp_regen", reg_en, 0);
    tick();

    instr = mk(OP_STORE, 2'b00);
    #1 check("st2_we", wr_en, 1);
    tick();
    check("st2_wait_we", wr_en, 1); check("st2_wait_pcen", pc_en, 0);
    reset = 1'b1;
    tick();
    check("abort_we", wr_en, 0); check("abort_pcen", pc_en, 0);
    check("abort_cnt", cnt, 0); check("abort_done", done, 0);
    reset = 1'b0;
    tick();
    check("abort_idle_we", wr_en, 0); check("abort_idle_regen", reg_en, 0);

    reset0 = 1'b0;
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0; instr0 = mk(OP_LOAD, 2'b00);
    #1 check("lat0_ld_pcen", pc_en0, 1); check("lat0_ld_regen", reg_en0, 1); check("lat0_ld_wb", reg_wb0, 0);
    tick();
    check("lat0_cnt1", cnt0, 1);
    instr0 = mk(OP_ADDI, 2'b00);
    tick(); tick();
    check("sat_cnt3", cnt0, 3);
    tick(); tick();
    check("sat_hold", cnt0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
